// File: rtl/lib_trial_pkg.sv
// Shared constants and types for the lib_trial APB/SPI integration block.
package lib_trial_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned RX_W     = 32;

  localparam logic [ADDR_W-1:0] ADDR_REG0     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_REG1     = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_REG2     = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_REG3     = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_RX_LO    = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_RX_HI    = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_RX_STAT  = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_UNMAPPED = 3'd7;

  typedef struct packed {
    logic       valid;
    logic       rsvd;
    logic [5:0] bits;
    logic [7:0] count;
  } rx_stat_t;

endpackage

// File: rtl/lib_trial_if.sv
// APB completer-side bus bundle for lib_trial, with requester/completer modports.
interface lib_trial_if;
  import lib_trial_pkg::*;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [1:0]        pstrb;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;
  logic              pready_o;
  logic              pslverr_o;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pready, pslverr,
    input  prdata, pready_o, pslverr_o
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pready, pslverr,
    output prdata, pready_o, pslverr_o
  );

endinterface

// File: rtl/lib_trial_spi_rx.sv
// SPI frame receiver: synchronizes sclk/cs_n/mosi, shifts MSB first, latches the frame on cs_n rise.
module lib_trial_spi_rx
  import lib_trial_pkg::*;
(
  input  logic            pclk,
  input  logic            preset,
  input  logic            sclk,
  input  logic            cs_n,
  input  logic            mosi,
  output logic [RX_W-1:0] rx_data,
  output logic [5:0]      rx_bits,
  output logic [7:0]      rx_count,
  output logic            rx_valid
);

  logic [1:0]      sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic            sclk_prev_q, cs_prev_q;
  logic            sclk_s, cs_s, mosi_s;
  logic            sclk_rise, cs_fall, cs_rise;

  logic [RX_W-1:0] shift_q, shift_d;
  logic [5:0]      bits_q, bits_d;
  logic            armed_q, armed_d;
  logic [RX_W-1:0] data_q, data_d;
  logic [5:0]      lbits_q, lbits_d;
  logic [7:0]      count_q, count_d;
  logic            valid_q, valid_d;

  assign sclk_s    = sclk_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  // Synchronizers idle with cs_n high so reset release never fakes a frame start.
  always_ff @(posedge pclk) begin
    if (preset) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      cs_sync_q   <= {cs_sync_q[0], cs_n};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  // Frame tracking; armed only after a cs_n fall so a reset mid-frame discards it.
  always_comb begin
    shift_d = shift_q;
    bits_d  = bits_q;
    armed_d = armed_q;
    data_d  = data_q;
    lbits_d = lbits_q;
    count_d = count_q;
    valid_d = valid_q;
    if (cs_fall) begin
      shift_d = '0;
      bits_d  = '0;
      armed_d = 1'b1;
    end else if (armed_q && !cs_s && sclk_rise) begin
      shift_d = {shift_q[RX_W-2:0], mosi_s};
      if (bits_q != 6'd63) bits_d = bits_q + 6'd1;
    end else if (armed_q && cs_rise) begin
      armed_d = 1'b0;
      if (bits_q != 6'd0) begin
        data_d  = shift_q;
        lbits_d = bits_q;
        count_d = count_q + 8'd1;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      shift_q <= '0;
      bits_q  <= '0;
      armed_q <= 1'b0;
      data_q  <= '0;
      lbits_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bits_q  <= bits_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      lbits_q <= lbits_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign rx_data  = data_q;
  assign rx_bits  = lbits_q;
  assign rx_count = count_q;
  assign rx_valid = valid_q;

endmodule

// File: rtl/lib_trial_tb.sv
// APB register bank with byte strobes and external wait/error injection.
// Optional SPI frame receiver enabled by defining LIB_TRIAL_SPI_EN.
module lib_trial_tb
  import lib_trial_pkg::*;
(
  input logic        pclk,
  input logic        preset,
  lib_trial_if.slave apb,
  input logic        sclk,
  input logic        cs_n,
  input logic        mosi
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] rx_lo, rx_hi;
  rx_stat_t          rx_stat;
  logic [DATA_W-1:0] rdata_c;
  logic              complete, bad_addr, err, wr_en;
  logic [1:0]        reg_idx;

  assign complete = apb.psel & apb.penable & apb.pready & ~preset;
  assign bad_addr = (apb.paddr == ADDR_UNMAPPED) | (apb.pwrite & (apb.paddr >= ADDR_RX_LO));
  assign err      = complete & (apb.pslverr | bad_addr);
  // Writes to RO/unmapped addresses always error, so ~err also bounds the target to REG0-3.
  assign wr_en    = complete & apb.pwrite & ~err;
  assign reg_idx  = apb.paddr[1:0];

  assign apb.pready_o  = complete;
  assign apb.pslverr_o = err;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && reg_idx == 2'(i)) begin
        if (apb.pstrb[0]) regs_d[i][7:0]  = apb.pwdata[7:0];
        if (apb.pstrb[1]) regs_d[i][15:8] = apb.pwdata[15:8];
      end
    end
  end

  always_ff @(posedge pclk) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (preset) regs_q[i] <= '0;
      else        regs_q[i] <= regs_d[i];
    end
  end

`ifdef LIB_TRIAL_SPI_EN
  logic [RX_W-1:0] rx_data;
  logic [5:0]      rx_bits;
  logic [7:0]      rx_count;
  logic            rx_valid;

  lib_trial_spi_rx u_spi_rx (
    .pclk     (pclk),
    .preset   (preset),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .rx_data  (rx_data),
    .rx_bits  (rx_bits),
    .rx_count (rx_count),
    .rx_valid (rx_valid)
  );

  assign rx_lo   = rx_data[15:0];
  assign rx_hi   = rx_data[31:16];
  assign rx_stat = '{valid: rx_valid, rsvd: 1'b0, bits: rx_bits, count: rx_count};
`else
  logic unused_spi;
  assign unused_spi = ^{sclk, cs_n, mosi};
  assign rx_lo      = '0;
  assign rx_hi      = '0;
  assign rx_stat    = '0;
`endif

  // Combinational read mux; a frame latched this cycle shows up on the next read.
  always_comb begin
    rdata_c = '0;
    if (apb.psel && !apb.pwrite && !preset) begin
      case (apb.paddr)
        ADDR_REG0, ADDR_REG1, ADDR_REG2, ADDR_REG3: rdata_c = regs_q[reg_idx];
        ADDR_RX_LO:   rdata_c = rx_lo;
        ADDR_RX_HI:   rdata_c = rx_hi;
        ADDR_RX_STAT: rdata_c = rx_stat;
        default:      rdata_c = '0;
      endcase
    end
  end

  assign apb.prdata = rdata_c;

endmodule

// File: tb/tb_lib_trial_tb.sv
// Directed bench for lib_trial_tb: APB vector table plus wait-state and SPI frame sequences.
module tb_lib_trial_tb;

  logic pclk = 1'b0;
  logic preset, sclk, cs_n, mosi;

  lib_trial_if apb();

  lib_trial_tb dut (
    .pclk   (pclk),
    .preset (preset),
    .apb    (apb.slave),
    .sclk   (sclk),
    .cs_n   (cs_n),
    .mosi   (mosi)
  );

  always #5 pclk = ~pclk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  strb;
    logic        err_inj;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [2:0] addr, input logic [15:0] wdata,
                          input logic [1:0] strb, input logic err_inj, input int waits,
                          output logic [15:0] rdata, output logic rdy, output logic serr);
    @(posedge pclk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = addr;
    apb.pwdata = wdata; apb.pstrb = strb; apb.pslverr = err_inj; apb.pready = 1'b0;
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    for (int w = 0; w < waits; w++) begin
      @(negedge pclk);
      check($sformatf("wait%0d_pready", w), 32'(apb.pready_o), 32'd0);
      @(posedge pclk); #1;
    end
    apb.pready = 1'b1;
    @(negedge pclk);
    rdata = apb.prdata;
    rdy   = apb.pready_o;
    serr  = apb.pslverr_o;
    @(posedge pclk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pready = 1'b0; apb.pslverr = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [2:0] addr, input logic [15:0] exp);
    logic [15:0] rd;
    logic        rdy, serr;
    apb_xfer(1'b0, addr, 16'h0, 2'b00, 1'b0, 0, rd, rdy, serr);
    check({name, "_rdata"}, 32'(rd), 32'(exp));
    check({name, "_err"}, 32'(serr), 32'd0);
  endtask

  task automatic spi_frame(input logic [63:0] data, input int nbits);
    @(posedge pclk); #1 cs_n = 1'b0;
    repeat (10) @(posedge pclk);
    for (int i = nbits - 1; i >= 0; i--) begin
      #1 mosi = data[i];
      repeat (5) @(posedge pclk);
      #1 sclk = 1'b1;
      repeat (5) @(posedge pclk);
      #1 sclk = 1'b0;
    end
    repeat (5) @(posedge pclk);
    #1 cs_n = 1'b1;
    repeat (10) @(posedge pclk);
  endtask

  initial begin
    logic [15:0] rd;
    logic        rdy, serr;

    //           wr    addr  wdata     strb   inj   exp_rdata exp_err
    vecs[0]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 3'd0, 16'hdead, 2'b11, 1'b0, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 3'd1, 16'h4ead, 2'b10, 1'b0, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 3'd2, 16'hfeed, 2'b01, 1'b0, 16'h0000, 1'b0};
    vecs[4]  = '{1'b1, 3'd3, 16'hfeed, 2'b00, 1'b0, 16'h0000, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 16'hdead, 1'b0};
    vecs[6]  = '{1'b0, 3'd1, 16'h0000, 2'b00, 1'b0, 16'h4e00, 1'b0};
    vecs[7]  = '{1'b0, 3'd2, 16'h0000, 2'b00, 1'b0, 16'h00ed, 1'b0};
    vecs[8]  = '{1'b0, 3'd3, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0};
    vecs[9]  = '{1'b1, 3'd0, 16'h1234, 2'b11, 1'b1, 16'h0000, 1'b1};
    vecs[10] = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 16'hdead, 1'b0};
    vecs[11] = '{1'b1, 3'd7, 16'h5a5a, 2'b11, 1'b0, 16'h0000, 1'b1};
    vecs[12] = '{1'b0, 3'd7, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b1};
    vecs[13] = '{1'b1, 3'd4, 16'hffff, 2'b11, 1'b0, 16'h0000, 1'b1};
    vecs[14] = '{1'b0, 3'd4, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0};
    vecs[15] = '{1'b0, 3'd6, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0};

    preset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 3'd0;
    apb.pwdata = 16'h0; apb.pstrb = 2'b00; apb.pready = 1'b0; apb.pslverr = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("reset_prdata", 32'(apb.prdata), 32'd0);
    check("reset_pready", 32'(apb.pready_o), 32'd0);
    check("reset_pslverr", 32'(apb.pslverr_o), 32'd0);
    @(posedge pclk); #1 preset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].err_inj, 0,
               rd, rdy, serr);
      check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_pready", i), 32'(rdy), 32'd1);
      check($sformatf("vec%0d_pslverr", i), 32'(serr), 32'(vecs[i].exp_err));
    end

    // Stalled write withdrawn before pready: REG1 must keep its value.
    @(posedge pclk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 3'd1;
    apb.pwdata = 16'h5555; apb.pstrb = 2'b11; apb.pready = 1'b0;
    @(posedge pclk); #1 apb.penable = 1'b1;
    for (int w = 0; w < 5; w++) begin
      @(negedge pclk);
      check($sformatf("stall%0d_pready", w), 32'(apb.pready_o), 32'd0);
      @(posedge pclk); #1;
    end
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    read_check("stall_noupdate", 3'd1, 16'h4e00);

    // Five wait states, then completion in the pready cycle.
    apb_xfer(1'b1, 3'd1, 16'h5555, 2'b11, 1'b0, 5, rd, rdy, serr);
    check("wait_complete_pready", 32'(rdy), 32'd1);
    check("wait_complete_err", 32'(serr), 32'd0);
    read_check("wait_update", 3'd1, 16'h5555);

    spi_frame(64'h0000_0000_17f3_ad08, 32);
`ifdef LIB_TRIAL_SPI_EN
    read_check("spi32_lo", 3'd4, 16'had08);
    read_check("spi32_hi", 3'd5, 16'h17f3);
    read_check("spi32_stat", 3'd6, 16'ha001);
`else
    read_check("spi32_lo", 3'd4, 16'h0000);
    read_check("spi32_hi", 3'd5, 16'h0000);
    read_check("spi32_stat", 3'd6, 16'h0000);
`endif

    spi_frame(64'h0000_0000_0000_dead, 16);
`ifdef LIB_TRIAL_SPI_EN
    read_check("spi16_lo", 3'd4, 16'hdead);
    read_check("spi16_hi", 3'd5, 16'h0000);
    read_check("spi16_stat", 3'd6, 16'h9002);
`else
    read_check("spi16_lo", 3'd4, 16'h0000);
    read_check("spi16_hi", 3'd5, 16'h0000);
    read_check("spi16_stat", 3'd6, 16'h0000);
`endif

    // 40-bit frame keeps only the last 32 bits shifted in.
    spi_frame(64'h0000_00ab_1234_5678, 40);
`ifdef LIB_TRIAL_SPI_EN
    read_check("spi40_lo", 3'd4, 16'h5678);
    read_check("spi40_hi", 3'd5, 16'h1234);
    read_check("spi40_stat", 3'd6, 16'ha803);
`else
    read_check("spi40_lo", 3'd4, 16'h0000);
    read_check("spi40_hi", 3'd5, 16'h0000);
    read_check("spi40_stat", 3'd6, 16'h0000);
`endif

    read_check("final_reg0", 3'd0, 16'hdead);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
